// File: rtl/md_if.sv
// Request/response bundle between the EX stage and the multiply/divide unit.
interface md_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Busy;
  logic             done;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (
    output start, op, A, B,
    input  Busy, done, HI, LO
  );

  modport slave (
    input  start, op, A, B,
    output Busy, done, HI, LO
  );
endinterface

// File: rtl/md_unit_param.sv
// Parametrised multiply/divide unit with HI/LO registers for the EX stage.
// Define MD_MADD_EN to enable op 7 (signed multiply-accumulate into {HI,LO}).
module md_unit_param #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5
) (
  input  logic clk,
  input  logic reset,
  md_if.slave  bus
);

  localparam int PW      = 2 * WIDTH;
  localparam int CNT_MAX = (WIDTH > MUL_LAT) ? WIDTH : MUL_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV_ITER,
    DIV_FIX
  } state_e;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_MADD  = 3'd7
  } op_e;

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic [PW-1:0]    prod;
  logic             is_madd;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] rem;
  logic             neg_q;
  logic             neg_r;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             busy_q;
  logic             done_q;

  op_e  op;
  logic madd_req;
  logic mul_req;
  logic div_req;

  assign op = op_e'(bus.op);

`ifdef MD_MADD_EN
  assign madd_req = (op == OP_MADD);
`else
  assign madd_req = 1'b0;
`endif

  assign mul_req = (op == OP_MULT) || (op == OP_MULTU) || madd_req;
  assign div_req = (op == OP_DIV) || (op == OP_DIVU);

  logic             sign_mul;
  logic [PW-1:0]    a_ext;
  logic [PW-1:0]    b_ext;
  logic [PW-1:0]    product;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] trial;
  logic             take;

  // Sign-extending both operands to 2*WIDTH lets one unsigned multiplier
  // serve mult, multu and madd; the low 2*WIDTH bits are exact in all cases.
  always_comb begin
    sign_mul = (op == OP_MULT) || madd_req;
    a_ext    = {{WIDTH{sign_mul & bus.A[WIDTH-1]}}, bus.A};
    b_ext    = {{WIDTH{sign_mul & bus.B[WIDTH-1]}}, bus.B};
    product  = a_ext * b_ext;

    a_neg = (op == OP_DIV) && bus.A[WIDTH-1];
    b_neg = (op == OP_DIV) && bus.B[WIDTH-1];
    a_mag = a_neg ? -bus.A : bus.A;
    b_mag = b_neg ? -bus.B : bus.B;

    // Restoring step: the quotient shifts into dvd as the dividend shifts out.
    shifted = {rem, dvd[WIDTH-1]};
    take    = (shifted >= {1'b0, dvs});
    trial   = shifted[WIDTH-1:0] - dvs;
  end

  // NOTE: the reset is synchronous, so it sits inside the clocked branch and
  // is not in the sensitivity list; every state register uses <= so all of
  // them update from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      prod    <= '0;
      is_madd <= 1'b0;
      dvd     <= '0;
      dvs     <= '0;
      rem     <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            if (mul_req) begin
              prod    <= product;
              is_madd <= madd_req;
              cnt     <= CNT_W'(MUL_LAT - 1);
              busy_q  <= 1'b1;
              state   <= MUL;
            end else if (div_req) begin
              dvd   <= a_mag;
              dvs   <= b_mag;
              rem   <= '0;
              // With B=0 the raw quotient is all ones and the remainder is |A|;
              // suppressing the quotient sign yields LO=~0 and HI=A directly.
              neg_q <= (a_neg ^ b_neg) && (bus.B != '0);
              neg_r <= a_neg;
              cnt    <= CNT_W'(WIDTH - 1);
              busy_q <= 1'b1;
              state  <= DIV_ITER;
            end else if (op == OP_MTHI) begin
              hi_q <= bus.A;
            end else if (op == OP_MTLO) begin
              lo_q <= bus.A;
            end
          end
        end

        MUL: begin
          if (cnt == '0) begin
            {hi_q, lo_q} <= is_madd ? ({hi_q, lo_q} + prod) : prod;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        DIV_ITER: begin
          rem <= take ? trial : shifted[WIDTH-1:0];
          dvd <= {dvd[WIDTH-2:0], take};
          if (cnt == '0) begin
            cnt   <= CNT_W'(1);
            state <= DIV_FIX;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        // First cycle applies the signs, second commits, keeping the
        // negation adders off the HI/LO write path.
        DIV_FIX: begin
          if (cnt != '0) begin
            if (neg_q) dvd <= -dvd;
            if (neg_r) rem <= -rem;
            cnt <= '0;
          end else begin
            lo_q   <= dvd;
            hi_q   <= rem;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Busy = busy_q;
  assign bus.done = done_q;
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;

endmodule
